// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - Pong ball FSM: serve, wall/paddle bounces, misses and lives (option: BALL_SPEEDUP_EN)
module ball_ctrl #(
    parameter int H_SIZE      = 8,
    parameter int IX          = 320,
    parameter int IY          = 120,
    parameter int D_WIDTH     = 640,
    parameter int D_HEIGHT    = 480,
    parameter int SERVE_DELAY = 60,
    parameter int LIVES       = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_serve,
    input  logic [11:0] i_pad_x1,
    input  logic [11:0] i_pad_x2,
    input  logic [11:0] i_pad_y1,
    input  logic [11:0] i_pad_y2,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic [2:0]  o_state,
    output logic [7:0]  o_hits,
    output logic [1:0]  o_lives,
    output logic        o_miss
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_MISS  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [11:0] L_H        = 12'(H_SIZE);
    localparam logic [11:0] L_IX       = 12'(IX);
    localparam logic [11:0] L_IY       = 12'(IY);
    localparam logic [11:0] L_XMAX     = 12'(D_WIDTH - 1);
    localparam logic [11:0] L_YMAX     = 12'(D_HEIGHT - 1);
    localparam logic [15:0] L_DLY_LAST = 16'(SERVE_DELAY - 1);
    localparam logic [1:0]  L_LIVES    = 2'(LIVES);

    logic [2:0]  r_state;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_dx;
    logic        r_dy;
    logic [7:0]  r_hits;
    logic [1:0]  r_lives;
    logic        r_miss;
    logic [15:0] r_delay;

    logic        w_frame;
    logic [11:0] w_step;
    logic [11:0] w_bot;
    logic        w_hit;
    logic        w_wall_r;
    logic        w_wall_l;
    logic        w_wall_t;
    logic        w_floor;

`ifdef BALL_SPEEDUP_EN
    // Hits since the last serve, saturated at 12 so the step tops out at 4.
    logic [3:0] r_srv_hits;

    assign w_step = {10'd0, r_srv_hits[3:2]} + 12'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_srv_hits <= 4'd0;
        end else if (w_frame) begin
            if (r_state == S_SERVE) begin
                r_srv_hits <= 4'd0;
            end else if (r_state == S_PLAY && w_hit && r_srv_hits != 4'd12) begin
                r_srv_hits <= r_srv_hits + 4'd1;
            end
        end
    end
`else
    assign w_step = 12'd1;
`endif

    assign w_frame  = i_animate & i_ani_stb;
    assign w_bot    = r_y + L_H;
    assign w_hit    = r_dy && (w_bot >= i_pad_y1) && (w_bot <= i_pad_y2)
                      && (r_x >= i_pad_x1) && (r_x <= i_pad_x2);
    // Wall tests are arranged so that no subtraction can wrap below zero.
    assign w_wall_r = (r_x + L_H + w_step) > L_XMAX;
    assign w_wall_l = r_x < (L_H + w_step);
    assign w_wall_t = r_y < (L_H + w_step);
    assign w_floor  = w_bot >= L_YMAX;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_x     <= L_IX;
            r_y     <= L_IY;
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
            r_hits  <= 8'd0;
            r_lives <= L_LIVES;
            r_miss  <= 1'b0;
            r_delay <= 16'd0;
        end else begin
            r_miss <= 1'b0;
            if (w_frame) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_serve) begin
                            r_state <= S_SERVE;
                            r_delay <= 16'd0;
                        end
                    end
                    S_SERVE: begin
                        if (r_delay == L_DLY_LAST) begin
                            r_state <= S_PLAY;
                            r_dx    <= 1'b1;
                            r_dy    <= 1'b1;
                            r_delay <= 16'd0;
                        end else begin
                            r_delay <= r_delay + 16'd1;
                        end
                    end
                    S_PLAY: begin
                        if (r_dx) begin
                            if (w_wall_r) r_dx <= 1'b0;
                            else          r_x  <= r_x + w_step;
                        end else begin
                            if (w_wall_l) r_dx <= 1'b1;
                            else          r_x  <= r_x - w_step;
                        end
                        if (r_dy) begin
                            if (w_hit) begin
                                r_dy <= 1'b0;
                                if (r_hits != 8'hFF) r_hits <= r_hits + 8'd1;
                            end else if (w_floor) begin
                                r_state <= S_MISS;
                                r_lives <= r_lives - 2'd1;
                                r_miss  <= 1'b1;
                            end else begin
                                r_y <= r_y + w_step;
                            end
                        end else begin
                            if (w_wall_t) r_dy <= 1'b1;
                            else          r_y  <= r_y - w_step;
                        end
                    end
                    S_MISS: begin
                        if (r_lives != 2'd0) begin
                            r_state <= S_SERVE;
                            r_x     <= L_IX;
                            r_y     <= L_IY;
                            r_delay <= 16'd0;
                        end else begin
                            r_state <= S_OVER;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_x1    = r_x - L_H;
    assign o_x2    = r_x + L_H;
    assign o_y1    = r_y - L_H;
    assign o_y2    = r_y + L_H;
    assign o_state = r_state;
    assign o_hits  = r_hits;
    assign o_lives = r_lives;
    assign o_miss  = r_miss;

endmodule

// File: tb/tb_ball_ctrl.sv
// tb/tb_ball_ctrl.sv - directed self-checking bench for ball_ctrl
module tb_ball_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        animate = 1'b1;
    logic        serve = 1'b0;
    logic [11:0] pad_x1 = 12'd0;
    logic [11:0] pad_x2 = 12'd0;
    logic [11:0] pad_y1 = 12'd0;
    logic [11:0] pad_y2 = 12'd0;
    logic [11:0] x1, x2, y1, y2;
    logic [2:0]  state;
    logic [7:0]  hits;
    logic [1:0]  lives;
    logic        miss;

    int n_checks = 0;
    int n_fail   = 0;

    ball_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(animate), .i_serve(serve),
        .i_pad_x1(pad_x1), .i_pad_x2(pad_x2), .i_pad_y1(pad_y1), .i_pad_y2(pad_y2),
        .o_x1(x1), .o_x2(x2), .o_y1(y1), .o_y2(y2),
        .o_state(state), .o_hits(hits), .o_lives(lives), .o_miss(miss)
    );

    always #5 clk = ~clk;

    task automatic frame();
        @(negedge clk) stb = 1'b1;
        @(negedge clk) stb = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives got %0d want 3", lives); end
        n_checks++; if (hits !== 8'd0) begin n_fail++; $display("FAIL reset_hits got %0d want 0", hits); end
        n_checks++; if (miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss got %0d want 0", miss); end
        n_checks++; if (x1 !== 12'd312 || x2 !== 12'd328 || y1 !== 12'd112 || y2 !== 12'd128) begin
            n_fail++; $display("FAIL reset_pos got %0d %0d %0d %0d want 312 328 112 128", x1, x2, y1, y2);
        end
    endtask

    task automatic test_serve();
        serve = 1'b1;
        frame();
        serve = 1'b0;
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL serve_enter got %0d want 1", state); end
        frames(59);
        n_checks++; if (state !== 3'd1 || x1 !== 12'd312 || y1 !== 12'd112) begin
            n_fail++; $display("FAIL serve_hold got st=%0d x1=%0d y1=%0d want 1 312 112", state, x1, y1);
        end
        animate = 1'b0;
        frames(5);
        animate = 1'b1;
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL animate_off got %0d want 1", state); end
        frame();
        n_checks++; if (state !== 3'd2 || x1 !== 12'd312 || y1 !== 12'd112) begin
            n_fail++; $display("FAIL play_enter got st=%0d x1=%0d y1=%0d want 2 312 112", state, x1, y1);
        end
    endtask

    task automatic test_paddle_hit();
        pad_x1 = 12'd240; pad_x2 = 12'd460; pad_y1 = 12'd248; pad_y2 = 12'd268;
        frames(120);
        n_checks++; if (x1 !== 12'd432 || y1 !== 12'd232 || hits !== 8'd0) begin
            n_fail++; $display("FAIL pre_hit got x1=%0d y1=%0d hits=%0d want 432 232 0", x1, y1, hits);
        end
        frame();
        n_checks++; if (hits !== 8'd1 || y1 !== 12'd232 || x1 !== 12'd433 || miss !== 1'b0) begin
            n_fail++; $display("FAIL hit got hits=%0d y1=%0d x1=%0d miss=%0d want 1 232 433 0", hits, y1, x1, miss);
        end
        frame();
        n_checks++; if (y1 !== 12'd231 || x1 !== 12'd434) begin
            n_fail++; $display("FAIL after_hit got y1=%0d x1=%0d want 231 434", y1, x1);
        end
    endtask

    task automatic test_corner();
        pad_x1 = 12'd0; pad_x2 = 12'd639; pad_y1 = 12'd306; pad_y2 = 12'd306;
        frames(813);
        n_checks++; if (x1 !== 12'd0 || y1 !== 12'd0 || hits !== 8'd2) begin
            n_fail++; $display("FAIL corner_reach got x1=%0d y1=%0d hits=%0d want 0 0 2", x1, y1, hits);
        end
        frame();
        n_checks++; if (x1 !== 12'd0 || y1 !== 12'd0 || state !== 3'd2) begin
            n_fail++; $display("FAIL corner_bounce got x1=%0d y1=%0d st=%0d want 0 0 2", x1, y1, state);
        end
        frame();
        n_checks++; if (x1 !== 12'd1 || y1 !== 12'd1) begin
            n_fail++; $display("FAIL corner_after got x1=%0d y1=%0d want 1 1", x1, y1);
        end
    endtask

    task automatic test_miss();
        pad_x1 = 12'd0; pad_x2 = 12'd0; pad_y1 = 12'd0; pad_y2 = 12'd0;
        frames(462);
        n_checks++; if (state !== 3'd2 || y2 !== 12'd479 || miss !== 1'b0) begin
            n_fail++; $display("FAIL pre_miss got st=%0d y2=%0d miss=%0d want 2 479 0", state, y2, miss);
        end
        frame();
        n_checks++; if (state !== 3'd3 || miss !== 1'b1 || lives !== 2'd2) begin
            n_fail++; $display("FAIL miss got st=%0d miss=%0d lives=%0d want 3 1 2", state, miss, lives);
        end
        @(negedge clk);
        n_checks++; if (miss !== 1'b0) begin n_fail++; $display("FAIL miss_pulse got %0d want 0", miss); end
        frame();
        n_checks++; if (state !== 3'd1 || x1 !== 12'd312 || y1 !== 12'd112 || lives !== 2'd2) begin
            n_fail++; $display("FAIL reserve got st=%0d x1=%0d y1=%0d lives=%0d want 1 312 112 2", state, x1, y1, lives);
        end
    endtask

    task automatic test_game_over();
        int cnt;
        for (int r = 0; r < 2; r++) begin
            cnt = 0;
            while (state !== 3'd3 && cnt < 600) begin
                frame();
                cnt++;
            end
            n_checks++; if (cnt != 412 || lives !== 2'(1 - r)) begin
                n_fail++; $display("FAIL round%0d got frames=%0d lives=%0d want 412 %0d", r, cnt, lives, 1 - r);
            end
            frame();
        end
        n_checks++; if (state !== 3'd4 || lives !== 2'd0) begin
            n_fail++; $display("FAIL over got st=%0d lives=%0d want 4 0", state, lives);
        end
        serve = 1'b1;
        frames(5);
        serve = 1'b0;
        n_checks++; if (state !== 3'd4 || x1 !== 12'd583) begin
            n_fail++; $display("FAIL over_frozen got st=%0d x1=%0d want 4 583", state, x1);
        end
        @(negedge clk) begin rst = 1'b1; stb = 1'b1; end
        @(negedge clk) begin rst = 1'b0; stb = 1'b0; end
        n_checks++; if (state !== 3'd0 || lives !== 2'd3 || hits !== 8'd0 || x1 !== 12'd312) begin
            n_fail++; $display("FAIL over_reset got st=%0d lives=%0d hits=%0d x1=%0d want 0 3 0 312", state, lives, hits, x1);
        end
    endtask

    task automatic test_reset_mid_play();
        serve = 1'b1;
        frame();
        serve = 1'b0;
        frames(70);
        n_checks++; if (state !== 3'd2 || x1 !== 12'd322 || y1 !== 12'd122) begin
            n_fail++; $display("FAIL mid_play got st=%0d x1=%0d y1=%0d want 2 322 122", state, x1, y1);
        end
        @(negedge clk) begin rst = 1'b1; stb = 1'b1; end
        @(negedge clk) begin rst = 1'b0; stb = 1'b0; end
        n_checks++; if (state !== 3'd0 || x1 !== 12'd312 || y1 !== 12'd112) begin
            n_fail++; $display("FAIL mid_reset got st=%0d x1=%0d y1=%0d want 0 312 112", state, x1, y1);
        end
        frame();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL idle_no_serve got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddle_hit();
        test_corner();
        test_miss();
        test_game_over();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_ctrl.md
BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 Parameter H_SIZE, default 8, half-size of the square ball in pixels.
REQ-002 Parameter IX / IY, default 320 / 120, serve position of the ball centre.
REQ-003 Parameter D_WIDTH / D_HEIGHT, default 640 / 480, display size.
REQ-004 Parameter SERVE_DELAY, default 60, frame strobes to wait in SERVE.
REQ-005 Parameter LIVES, default 3, misses allowed before game over.
REQ-006 Port i_clk, input, 1, base clock.
REQ-007 Port i_rst, input, 1, synchronous active-high reset.
REQ-008 Port i_ani_stb, input, 1, one-cycle frame strobe.
REQ-009 Port i_animate, input, 1, enables frame updates.
REQ-010 Port i_serve, input, 1, serve request, level.
REQ-011 Ports i_pad_x1, i_pad_x2, i_pad_y1, i_pad_y2, inputs, 12 each, paddle edges from the paddle block.
REQ-012 Ports o_x1, o_x2, o_y1, o_y2, outputs, 12 each, ball edges (centre -/+ H_SIZE, combinational from the centre registers).
REQ-013 Port o_state, output, 3, FSM state: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
REQ-014 Port o_hits, output, 8, paddle-hit count.
REQ-015 Port o_lives, output, 2, remaining lives.
REQ-016 Port o_miss, output, 1, one-i_clk-cycle pulse on each miss.

Function
REQ-017 A "frame" is any cycle with i_animate && i_ani_stb; all state, position, counter and direction updates occur only on frames, except reset.
REQ-018 IDLE: ball is held at IX,IY, and the block goes to SERVE on a frame with i_serve=1.
REQ-019 SERVE: ball is held at IX,IY, and the delay counter counts frames; after SERVE_DELAY frames the block goes to PLAY, dir_x=right and dir_y=down.
REQ-020 PLAY: each frame, x moves by step in dir_x and y by step in dir_y, where step=1 unless REQ-031 applies.
REQ-021 Left wall: if dir_x=left and x-H_SIZE < step, then dir_x<=right and x is unchanged that frame; right wall: if dir_x=right and x+H_SIZE+step > D_WIDTH-1, the mirror behaviour applies.
REQ-022 Top wall: if dir_y=up and y-H_SIZE < step, then dir_y<=down and y is unchanged that frame.
REQ-023 Paddle hit: if dir_y=down, y+H_SIZE is within [i_pad_y1, i_pad_y2] and x is within [i_pad_x1, i_pad_x2] (inclusive), then dir_y<=up, y is unchanged that frame, and o_hits increments, saturating at 255.
REQ-024 Miss: if dir_y=down and y+H_SIZE >= D_HEIGHT-1 and no hit is detected, the block goes to MISS, o_lives decrements and o_miss pulses for one cycle.
REQ-025 Priority within a frame: paddle hit > miss; x and y wall bounces are independent, so corners reverse both directions in the same frame.
REQ-026 MISS: on the next frame the block goes to SERVE if o_lives>0, else to OVER; ball position is held.
REQ-027 OVER: ball is frozen and i_serve is ignored; only i_rst exits OVER.
REQ-028 With i_animate=0 all registers hold; strobes are not counted.
REQ-029 All position arithmetic is 12-bit unsigned, and no intermediate result may wrap below 0.

Reset
REQ-030 On i_rst (any state, including mid-PLAY), on the next clock the block enters IDLE with x=IX, y=IY, dir_x=right, dir_y=down, o_hits=0, o_lives=LIVES, o_miss=0, delay counter=0 and step=1; i_rst overrides a simultaneous frame.

Configuration
REQ-031 With BALL_SPEEDUP_EN defined, step = 1 + floor(hits-since-serve/4), capped at 4, and resets to 1 on entering SERVE.
REQ-032 With BALL_SPEEDUP_EN undefined, step is constant 1 and no speed logic is present.

Verification
REQ-033 Reset, then i_serve held for 1 frame, then 60 frames -> o_state goes 0->1->2; during SERVE o_x1=312 and o_y1=112.
REQ-034 In PLAY, ball centre (320,240) moving down, paddle x1=240, x2=400, y1=248, y2=268 -> dir_y flips up on that frame, o_hits=1, o_miss stays 0.
REQ-035 Paddle moved away, ball descending -> at y+8=479 o_miss pulses for exactly 1 clk, o_lives 3->2, o_state 3 then 1.
REQ-036 Three misses -> o_state=4 and o_lives=0; i_serve ignored; i_rst -> o_state=0, o_lives=3.
REQ-037 Ball centre (8,8) moving up-left -> both directions reverse in the same frame; x and y unchanged that frame.
REQ-038 With BALL_SPEEDUP_EN: 4 hits -> per-frame x delta 2; 16 hits -> delta 4 and stays 4; after a miss and serve -> delta 1.
